// File: rtl/rev_pipe_pkg.sv
// ---------------------------------------------------------------------------
// rev_pipe_pkg
// Shared types for the reversible multiplier pipeline buffer.
//   dir_e         : stage direction (FWD = 0, BWD = 1)
//   pipe_state_e  : buffer control FSM states
//   PW_DEF/AW_DEF : default product / A pass-through widths
//   mult_entry_t  : one buffer entry {p, a_b} at the default widths
// ---------------------------------------------------------------------------
package rev_pipe_pkg;

  localparam int PW_DEF = 16;
  localparam int AW_DEF = 8;

  typedef enum logic {
    FWD = 1'b0,
    BWD = 1'b1
  } dir_e;

  typedef enum logic [1:0] {
    ST_FWD          = 2'd0,
    ST_BWD          = 2'd1,
    ST_DRAIN_TO_BWD = 2'd2,
    ST_DRAIN_TO_FWD = 2'd3
  } pipe_state_e;

  typedef struct packed {
    logic [PW_DEF-1:0] p;
    logic [AW_DEF-1:0] a_b;
  } mult_entry_t;

endpackage

// File: rtl/rev_fifo_core.sv
// ---------------------------------------------------------------------------
// rev_fifo_core
// DEPTH-entry circular buffer shared by both traffic directions.
//   clk, rst_n : clock, asynchronous active-low reset (control only)
//   push, din  : write request and data; ignored when full
//   pop        : read request; ignored when empty
//   dout       : head entry (meaningful only when !empty)
//   full, empty, count : occupancy status, all derived from registers
// Storage is not reset; only pointers and count are.
// ---------------------------------------------------------------------------
module rev_fifo_core #(
  parameter int DEPTH = 2,
  parameter int W     = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];
  assign count   = cnt_q;

  // storage write: data path, no reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/mult8_rev_pipe.sv
// ---------------------------------------------------------------------------
// mult8_rev_pipe
// Bidirectional buffer directly after the reversible 8-bit multiplier.
// Forward traffic (product + A pass-through) goes up_* -> dn_*; backward
// traffic goes bk_in_* -> bk_out_* (feeding the multiplier's r_p / r_a_b).
// The stage direction `dir` only flips once the buffer has drained, so the
// multiplier never sees a direction change with entries in flight.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   dir_req             : requested direction (0 fwd, 1 bwd)
//   dir, dir_busy       : current direction, change pending
//   up_*  / dn_*        : forward input / output handshakes and data
//   bk_in_* / bk_out_*  : backward input / output handshakes and data
//   zero_a_err          : sticky, backward entry accepted with a_b == 0
//   occupancy           : current entry count
// All handshake outputs depend only on registered state, so there is no
// combinational path from any ready input to any ready output.
// ---------------------------------------------------------------------------
module mult8_rev_pipe
  import rev_pipe_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PW    = PW_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     dir_req,
  output logic                     dir,
  output logic                     dir_busy,
  input  logic                     up_valid,
  output logic                     up_ready,
  input  logic [PW-1:0]            up_p,
  input  logic [AW-1:0]            up_a_b,
  output logic                     dn_valid,
  input  logic                     dn_ready,
  output logic [PW-1:0]            dn_p,
  output logic [AW-1:0]            dn_a_b,
  input  logic                     bk_in_valid,
  output logic                     bk_in_ready,
  input  logic [PW-1:0]            bk_in_p,
  input  logic [AW-1:0]            bk_in_a_b,
  output logic                     bk_out_valid,
  input  logic                     bk_out_ready,
  output logic [PW-1:0]            bk_out_p,
  output logic [AW-1:0]            bk_out_a_b,
  output logic                     zero_a_err,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int EW = PW + AW;

  pipe_state_e           state;
  dir_e                  dir_q;
  logic                  err_q;
  logic                  fwd_side;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [EW-1:0]         fifo_din;
  logic [EW-1:0]         fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                  bk_push;

  // the output side keeps popping during a drain, so DRAIN_TO_BWD still
  // empties through dn_* and DRAIN_TO_FWD through bk_out_*
  assign fwd_side = (state == ST_FWD) || (state == ST_DRAIN_TO_BWD);

  assign up_ready     = (state == ST_FWD) && !fifo_full;
  assign bk_in_ready  = (state == ST_BWD) && !fifo_full;
  assign dn_valid     = fwd_side && !fifo_empty;
  assign bk_out_valid = !fwd_side && !fifo_empty;

  assign bk_push   = bk_in_valid && bk_in_ready;
  assign fifo_push = (up_valid && up_ready) || bk_push;
  assign fifo_pop  = (dn_valid && dn_ready) || (bk_out_valid && bk_out_ready);
  assign fifo_din  = (state == ST_FWD) ? {up_p, up_a_b} : {bk_in_p, bk_in_a_b};

  // data outputs read as zero whenever their valid is low
  assign dn_p       = dn_valid     ? fifo_dout[EW-1:AW] : '0;
  assign dn_a_b     = dn_valid     ? fifo_dout[AW-1:0]  : '0;
  assign bk_out_p   = bk_out_valid ? fifo_dout[EW-1:AW] : '0;
  assign bk_out_a_b = bk_out_valid ? fifo_dout[AW-1:0]  : '0;

  assign dir        = dir_q;
  assign dir_busy   = (state == ST_DRAIN_TO_BWD) || (state == ST_DRAIN_TO_FWD);
  assign zero_a_err = err_q;
  assign occupancy  = fifo_count;

  rev_fifo_core #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // direction FSM: a reverted request wins over a completed drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FWD;
      dir_q <= FWD;
    end else begin
      case (state)
        ST_FWD: begin
          if (dir_req) begin
            state <= ST_DRAIN_TO_BWD;
          end
        end
        ST_DRAIN_TO_BWD: begin
          if (!dir_req) begin
            state <= ST_FWD;
          end else if (fifo_empty) begin
            state <= ST_BWD;
            dir_q <= BWD;
          end
        end
        ST_BWD: begin
          if (!dir_req) begin
            state <= ST_DRAIN_TO_FWD;
          end
        end
        ST_DRAIN_TO_FWD: begin
          if (dir_req) begin
            state <= ST_BWD;
          end else if (fifo_empty) begin
            state <= ST_FWD;
            dir_q <= FWD;
          end
        end
        default: begin
          state <= ST_FWD;
          dir_q <= FWD;
        end
      endcase
    end
  end

  // sticky error: a zero A on the reverse path cannot be un-multiplied
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (bk_push && (bk_in_a_b == '0)) begin
      err_q <= 1'b1;
    end
  end

endmodule
